wb_register_file: RTL

- 16 x 16-bit general-purpose register file at the write-back end of the CPU datapath.
- The main write port takes the 16-bit result chosen by the write-back data select mux (ALU, memory, immediate or link value).
- A second, dedicated write port updates R15 with the implicit high-product/remainder result from multiply/divide.
- Two combinational read ports feed the decode/operand stage, plus a dedicated R15 tap.

---
 rtl/wb_register_file_if.sv | 30 +++
 rtl/wb_register_file.sv | 97 +++++++++
 2 files changed

// File: rtl/wb_register_file_if.sv
// Write-back register file bus interface.
// Groups the write ports, read ports and status output of wb_register_file.
//   master : drives write/read requests and samples read data and wr_count
//   slave  : the register file itself
interface wb_register_file_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              r15_wr_en;
  logic [DATA_W-1:0] r15_wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] r15_data;
  logic [7:0]        wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, r15_wr_en, r15_wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, r15_data, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, r15_wr_en, r15_wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, r15_data, wr_count
  );
endinterface

// File: rtl/wb_register_file.sv
// Write-back register file: 2**ADDR_W x DATA_W general-purpose registers.
// Ports:
//   clk  : rising-edge clock for all writes
//   rst  : asynchronous active-low reset, clears all registers and wr_count
//   bus  : wb_register_file_if.slave
//          main write port (wr_en/wr_addr/wr_data), dedicated R15 write port
//          (r15_wr_en/r15_wr_data) with priority over the main port, two
//          combinational read ports, r15_data tap, saturating 8-bit wr_count.
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-through forwarding
// on rd_data1, rd_data2 and r15_data, active only while rst is high.
module wb_register_file #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned R15_IDX = 15
) (
  input logic                clk,
  input logic                rst,
  wb_register_file_if.slave  bus
);

  localparam int unsigned       NumRegs = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R15Addr = ADDR_W'(R15_IDX);

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [7:0]        wr_count_q;
  logic [7:0]        wr_count_d;

  // Next-state: dedicated R15 port is applied last so it wins a conflict.
  always_comb begin
    for (int i = 0; i < int'(NumRegs); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.wr_en) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
    if (bus.r15_wr_en) begin
      regs_d[R15Addr] = bus.r15_wr_data;
    end
  end

  // A cycle with both ports active counts once; holds at 255.
  always_comb begin
    wr_count_d = wr_count_q;
    if ((bus.wr_en || bus.r15_wr_en) && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q <= wr_count_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward in-flight write data to a matching read address; R15 port first.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (rst) begin
      if (bus.r15_wr_en && (addr == R15Addr)) begin
        val = bus.r15_wr_data;
      end else if (bus.wr_en && (addr == bus.wr_addr)) begin
        val = bus.wr_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    bus.rd_data1 = fwd(bus.rd_addr1, regs_q[bus.rd_addr1]);
    bus.rd_data2 = fwd(bus.rd_addr2, regs_q[bus.rd_addr2]);
    bus.r15_data = fwd(R15Addr, regs_q[R15Addr]);
  end
`else
  always_comb begin
    bus.rd_data1 = regs_q[bus.rd_addr1];
    bus.rd_data2 = regs_q[bus.rd_addr2];
    bus.r15_data = regs_q[R15Addr];
  end
`endif

  assign bus.wr_count = wr_count_q;

endmodule
